iso14443a_miller_encoder: RTL and testbench

- Reader-side frame encoder for ISO14443-A.
- Takes bytes from the ARM-facing deserializer over a valid/ready handshake and frames them. Frame = SOF, data bits with optional odd parity, EOF.
- Outputs a modified-Miller pause signal at 13.56 MHz rate.
- The signal drives the READER_MOD carrier-drop path: pwr_hi is gated off while mod_pause=1.

---
 rtl/iso14443a_miller_encoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_iso14443a_miller_encoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iso14443a_miller_encoder.sv
// ISO14443-A reader-side modified-Miller frame encoder; mod_pause rises 2 cycles after the first byte is accepted.
// One-byte holding register: data_ready low while full; a missing byte at a byte boundary ends the frame with underrun.
module iso14443a_miller_encoder #(
   parameter int BIT_PERIOD  = 128,
   parameter int PAUSE_LEN   = 32,
   parameter int HALF_OFFSET = 64
) (
   input  logic       ck_1356meg,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic       data_last,
   input  logic       short_frame,
   input  logic       parity_en,
   output logic       data_ready,
   output logic       mod_pause,
   output logic       busy,
   output logic       underrun
);

   localparam int            PW         = $clog2(BIT_PERIOD);
   localparam logic [PW-1:0] PHASE_LAST = PW'(BIT_PERIOD - 1);
   localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_DATA,
      ST_PARITY,
      ST_EOF0,
      ST_EOFY
   } state_t;

   typedef enum logic [1:0] {
      SYM_Y,
      SYM_X,
      SYM_Z
   } sym_t;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [7:0]    hold_dat_q, hold_dat_d;
   logic          hold_last_q, hold_last_d;
   logic          hold_short_q, hold_short_d;
   logic          hold_par_q, hold_par_d;
   logic          hold_full_q, hold_full_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_bit_q, par_bit_d;
   logic          cur_last_q, cur_last_d;
   logic          short_q, short_d;
   logic          par_en_q, par_en_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          prev_q, prev_d;
   logic          mod_q, mod_d;
   logic          busy_q, busy_d;
   logic          underrun_q, underrun_d;

   logic          period_end;
   logic          cur_bit;
   logic          load;
   logic          boundary;
   logic [2:0]    last_idx;
   sym_t          sym;
   logic          pause;

   assign data_ready = ~hold_full_q;
   assign mod_pause  = mod_q;
   assign busy       = busy_q;
   assign underrun   = underrun_q;

   assign period_end = (phase_q == PHASE_LAST);
   assign last_idx   = short_q ? 3'd6 : 3'd7;
   assign cur_bit    = (state_q == ST_PARITY) ? par_bit_q : shift_q[0];

   // Symbol of the current bit period; EOF0 is a logic 0 and follows the same prev_bit rule.
   always_comb begin
      sym = SYM_Y;
      unique case (state_q)
         ST_SOF:               sym = SYM_Z;
         ST_DATA, ST_PARITY:   sym = cur_bit ? SYM_X : (prev_q ? SYM_Y : SYM_Z);
         ST_EOF0:              sym = prev_q ? SYM_Y : SYM_Z;
         default:              sym = SYM_Y;
      endcase
   end

   always_comb begin
      pause = 1'b0;
      if (sym == SYM_Z) begin
         pause = (int'(phase_q) < PAUSE_LEN);
      end else if (sym == SYM_X) begin
         pause = (int'(phase_q) >= HALF_OFFSET) && (int'(phase_q) < HALF_OFFSET + PAUSE_LEN);
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      hold_dat_d   = hold_dat_q;
      hold_last_d  = hold_last_q;
      hold_short_d = hold_short_q;
      hold_par_d   = hold_par_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      par_bit_d    = par_bit_q;
      cur_last_d   = cur_last_q;
      short_d      = short_q;
      par_en_d     = par_en_q;
      bit_idx_d    = bit_idx_q;
      prev_d       = prev_q;
      underrun_d   = 1'b0;
      load         = 1'b0;
      boundary     = 1'b0;

      if (state_q == ST_IDLE || period_end) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + PHASE_ONE;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
               load     = 1'b1;
               state_d  = ST_SOF;
               short_d  = hold_short_q;
               par_en_d = hold_par_q;
               prev_d   = 1'b0;
            end
         end
         ST_SOF: begin
            prev_d = 1'b0;
            if (period_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (period_end) begin
               prev_d = cur_bit;
               if (bit_idx_q == last_idx) begin
                  if (par_en_q && !short_q) begin
                     state_d = ST_PARITY;
                  end else begin
                     boundary = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end
         ST_PARITY: begin
            if (period_end) begin
               prev_d   = cur_bit;
               boundary = 1'b1;
            end
         end
         ST_EOF0: begin
            if (period_end) begin
               state_d = ST_EOFY;
            end
         end
         ST_EOFY: begin
            if (period_end) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // short_frame always closes after one byte, whatever the last flag says.
      if (boundary) begin
         if (!cur_last_q && !short_q && hold_full_q) begin
            load    = 1'b1;
            state_d = ST_DATA;
         end else begin
            state_d    = ST_EOF0;
            underrun_d = !cur_last_q && !short_q;
         end
      end

      if (load) begin
         shift_d     = hold_dat_q;
         par_bit_d   = ~^hold_dat_q;
         cur_last_d  = hold_last_q;
         bit_idx_d   = 3'd0;
         hold_full_d = 1'b0;
      end

      if (data_valid && !hold_full_q) begin
         hold_dat_d   = data_in;
         hold_last_d  = data_last;
         hold_short_d = short_frame;
         hold_par_d   = parity_en;
         hold_full_d  = 1'b1;
      end
   end

   // Outputs are registered from the current state, so they trail the state by one cycle.
   assign mod_d  = pause;
   assign busy_d = (state_q != ST_IDLE);

   always_ff @(posedge ck_1356meg or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         hold_dat_q   <= 8'h00;
         hold_last_q  <= 1'b0;
         hold_short_q <= 1'b0;
         hold_par_q   <= 1'b0;
         hold_full_q  <= 1'b0;
         shift_q      <= 8'h00;
         par_bit_q    <= 1'b0;
         cur_last_q   <= 1'b0;
         short_q      <= 1'b0;
         par_en_q     <= 1'b0;
         bit_idx_q    <= 3'd0;
         prev_q       <= 1'b0;
         mod_q        <= 1'b0;
         busy_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         hold_dat_q   <= hold_dat_d;
         hold_last_q  <= hold_last_d;
         hold_short_q <= hold_short_d;
         hold_par_q   <= hold_par_d;
         hold_full_q  <= hold_full_d;
         shift_q      <= shift_d;
         par_bit_q    <= par_bit_d;
         cur_last_q   <= cur_last_d;
         short_q      <= short_d;
         par_en_q     <= par_en_d;
         bit_idx_q    <= bit_idx_d;
         prev_q       <= prev_d;
         mod_q        <= mod_d;
         busy_q       <= busy_d;
         underrun_q   <= underrun_d;
      end
   end

endmodule

// File: tb/tb_iso14443a_miller_encoder.sv
// Bench for iso14443a_miller_encoder: frames are predicted from the symbol rules and compared per busy window.
module tb_iso14443a_miller_encoder;

   localparam int SZ = 0;
   localparam int SX = 1;
   localparam int SY = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_last = 1'b0;
   logic       short_frame = 1'b0;
   logic       parity_en = 1'b0;
   logic       data_ready;
   logic       mod_pause;
   logic       busy;
   logic       underrun;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit [4095:0] wave;
      int          len;
      int          und;
      int          gap;
   } exp_t;

   exp_t       sb[$];
   bit [7:0]   fb[$];

   always #5 clk = ~clk;

   iso14443a_miller_encoder dut (
      .ck_1356meg (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_last  (data_last),
      .short_frame(short_frame),
      .parity_en  (parity_en),
      .data_ready (data_ready),
      .mod_pause  (mod_pause),
      .busy       (busy),
      .underrun   (underrun)
   );

   function automatic int enc(input bit b, input bit prev);
      if (b) return SX;
      if (prev) return SY;
      return SZ;
   endfunction

   // Reference: list of Miller symbols per bit period, then expanded to per-cycle pause levels.
   function automatic exp_t model(input int n, input bit sf, input bit pe, input bit drop, input int gap);
      exp_t     e;
      int       syms[$];
      bit       prev;
      bit [7:0] v;
      int       nsent, nb, ones, ph;
      e.wave = '0;
      e.und  = -1;
      e.gap  = gap;
      nsent  = (drop || sf) ? 1 : n;
      syms.push_back(SZ);
      prev = 1'b0;
      for (int k = 0; k < nsent; k++) begin
         v  = fb[k];
         nb = sf ? 7 : 8;
         for (int i = 0; i < nb; i++) begin
            syms.push_back(enc(v[i], prev));
            prev = v[i];
         end
         if (pe && !sf) begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(v[i]);
            syms.push_back(enc((ones % 2) == 0, prev));
            prev = ((ones % 2) == 0);
         end
      end
      if (drop) e.und = syms.size() * 128 - 1;
      syms.push_back(enc(1'b0, prev));
      syms.push_back(SY);
      e.len = syms.size() * 128;
      for (int k = 0; k < e.len; k++) begin
         ph = k % 128;
         if (syms[k / 128] == SZ) e.wave[k] = (ph < 32);
         else if (syms[k / 128] == SX) e.wave[k] = (ph >= 64) && (ph < 96);
      end
      return e;
   endfunction

   task automatic send_byte(input bit [7:0] b, input bit last, input bit sf, input bit pe);
      int w;
      @(negedge clk);
      data_in     = b;
      data_valid  = 1'b1;
      data_last   = last;
      short_frame = sf;
      parity_en   = pe;
      w = 0;
      while (!data_ready && w < 20000) begin
         @(negedge clk);
         w++;
      end
      if (!data_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: data_ready=%0b, required 1 within 20000 cycles", data_ready);
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      data_in    = 8'($urandom);
      data_last  = 1'($urandom);
   endtask

   task automatic send_frame(input int n, input bit sf, input bit pe, input bit drop, input int gap);
      int cnt;
      sb.push_back(model(n, sf, pe, drop, gap));
      if (drop) begin
         send_byte(fb[0], 1'b0, sf, pe);
      end else begin
         cnt = sf ? 1 : n;
         for (int i = 0; i < cnt; i++) begin
            send_byte(fb[i], (i == cnt - 1), sf, pe);
            repeat ($urandom_range(0, 20)) @(negedge clk);
         end
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((sb.size() != 0 || busy) && w < 20000) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0 || busy) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: pending=%0d busy=%0b, required 0/0", sb.size(), busy);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Monitor: captures each busy window and compares it against the oldest prediction.
   int          stray = 0;
   initial begin
      bit          cap, abort;
      int          idx, und, nund, gap_meas, fall_cyc, cyc, first;
      bit [4095:0] wv;
      exp_t        e;
      cap = 0; abort = 0; idx = 0; und = -1; nund = 0; gap_meas = 0;
      fall_cyc = -1000; cyc = 0; wv = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cap && !rst_n) abort = 1;
         if (cap && !busy) begin
            cap = 0;
            fall_cyc = cyc;
            if (abort) begin
               if (sb.size() > 0) void'(sb.pop_front());
            end else if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame: got frame of %0d cycles, required none", idx);
            end else begin
               e = sb.pop_front();
               tests++;
               if (idx != e.len) begin
                  fails++;
                  $display("FAIL frame_len: got %0d cycles, required %0d", idx, e.len);
               end
               tests++;
               if (wv != e.wave) begin
                  first = -1;
                  for (int k = 0; k < 4096; k++) begin
                     if (wv[k] != e.wave[k]) begin
                        first = k;
                        break;
                     end
                  end
                  fails++;
                  $display("FAIL mod_wave: offset %0d got %b, required %b", first, wv[first], e.wave[first]);
               end
               tests++;
               if (und != e.und || nund != ((e.und >= 0) ? 1 : 0)) begin
                  fails++;
                  $display("FAIL underrun: got offset %0d count %0d, required offset %0d", und, nund, e.und);
               end
               if (e.gap >= 0) begin
                  tests++;
                  if (gap_meas != e.gap) begin
                     fails++;
                     $display("FAIL frame_gap: got %0d idle cycles, required %0d", gap_meas, e.gap);
                  end
               end
            end
         end else if (!cap && busy) begin
            cap = 1; abort = 0; idx = 0; und = -1; nund = 0; wv = '0;
            gap_meas = cyc - fall_cyc;
         end
         if (cap && busy) begin
            if (idx < 4096) wv[idx] = mod_pause;
            if (underrun) begin
               und = idx;
               nund++;
            end
            idx++;
         end else if (!busy && (mod_pause || underrun)) begin
            stray++;
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, w;
      bit sf, pe, drop;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check1("reset_mod_pause", mod_pause, 1'b0);
      check1("reset_busy", busy, 1'b0);
      check1("reset_underrun", underrun, 1'b0);
      check1("reset_data_ready", data_ready, 1'b1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      fb = {8'h26};
      send_frame(1, 1'b1, 1'b0, 1'b0, -1);
      wait_idle();

      fb = {8'h93, 8'h20};
      send_frame(2, 1'b0, 1'b1, 1'b0, -1);
      fb = {8'h26};
      send_frame(1, 1'b1, 1'b0, 1'b0, 1);
      wait_idle();

      fb = {8'h50};
      send_frame(1, 1'b0, 1'b0, 1'b1, -1);
      wait_idle();

      fb = {8'h26};
      send_frame(1, 1'b1, 1'b0, 1'b0, -1);
      w = 0;
      while (!busy && w < 1000) begin
         @(negedge clk);
         w++;
      end
      repeat (330) @(negedge clk);
      check1("pre_reset_pause", mod_pause, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check1("async_reset_mod_pause", mod_pause, 1'b0);
      check1("async_reset_busy", busy, 1'b0);
      check1("async_reset_data_ready", data_ready, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      fb = {8'hA5};
      send_frame(1, 1'b0, 1'b1, 1'b0, -1);
      wait_idle();

      for (int f = 0; f < 14; f++) begin
         sf   = ($urandom % 5) == 0;
         n    = sf ? 1 : $urandom_range(1, 3);
         pe   = 1'($urandom);
         drop = !sf && (($urandom % 6) == 0);
         fb.delete();
         for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
         send_frame(n, sf, pe, drop, -1);
         if (drop) wait_idle();
      end
      wait_idle();

      tests++;
      if (stray != 0) begin
         fails++;
         $display("FAIL idle_outputs: got %0d active cycles outside frames, required 0", stray);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
